// File: rtl/raisin64_imem_pkg.sv
// Shared types and constants for the imem responder: FSM states, beat count,
// halfword/window widths and a helper that drops one halfword into a window slot.
package raisin64_imem_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} imem_state_t;

  localparam int IMEM_BEATS = 4;
  localparam int IMEM_HW_W  = 16;
  localparam int IMEM_WIN_W = 64;

  // Slot 0 is the first halfword fetched and lands in the top of the window.
  function automatic logic [IMEM_WIN_W-1:0] put_hw(input logic [IMEM_WIN_W-1:0] win,
                                                   input logic [1:0]            slot,
                                                   input logic [IMEM_HW_W-1:0]  hw);
    logic [IMEM_WIN_W-1:0] w;
    w = win;
    case (slot)
      2'd0:    w[63:48] = hw;
      2'd1:    w[47:32] = hw;
      2'd2:    w[31:16] = hw;
      default: w[15:0]  = hw;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_last_hit.sv
// One-entry buffer of the last completed window (tag, data, valid) with tag compare.
// Only instantiated when IMEM_LAST_HIT_EN is defined.
module imem_last_hit
  import raisin64_imem_pkg::*;
#(
  parameter int TAG_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_W-1:0]      lookup_tag,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [IMEM_WIN_W-1:0] fill_data,
  input  logic                  inval,
  output logic                  hit,
  output logic [IMEM_WIN_W-1:0] hit_data
);

  logic                  valid_q;
  logic [TAG_W-1:0]      tag_q;
  logic [IMEM_WIN_W-1:0] data_q;

  // Invalidate beats a simultaneous refill so stale fetch state is never kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill_en) begin
        tag_q  <= fill_tag;
        data_q <= fill_data;
      end
      if (inval)        valid_q <= 1'b0;
      else if (fill_en) valid_q <= 1'b1;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_data = data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: reads four halfwords from a synchronous 16-bit RAM
// and returns one 64-bit window. Optional last-hit buffer under IMEM_LAST_HIT_EN.
module imem_responder
  import raisin64_imem_pkg::*;
#(
  parameter int MEM_AW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           imem_addr,
  input  logic                  imem_addr_valid,
  input  logic                  imem_inval,
  output logic [IMEM_WIN_W-1:0] imem_data,
  output logic                  imem_data_valid,
  output logic                  imem_fault,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_en,
  input  logic [IMEM_HW_W-1:0]  mem_rdata
);

  // Handshake: a request is taken only when imem_addr_valid is high in IDLE;
  // imem_data_valid is a one-cycle pulse with no backpressure from fetch.
  imem_state_t           state;
  logic [MEM_AW-1:0]     base;
  logic                  fault_q;
  logic [1:0]            beat;
  logic [IMEM_WIN_W-1:0] win_q;
  logic [MEM_AW-1:0]     req_base;

  assign req_base = imem_addr[MEM_AW:1];

`ifdef IMEM_LAST_HIT_EN
  logic                  hit;
  logic [IMEM_WIN_W-1:0] hit_data;

  imem_last_hit #(.TAG_W(MEM_AW)) u_last_hit (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (req_base),
    .fill_en    (state == DONE),
    .fill_tag   (base),
    .fill_data  (imem_data),
    .inval      (imem_inval),
    .hit        (hit),
    .hit_data   (hit_data)
  );
`endif

  logic unused_bits;
  assign unused_bits = ^{imem_addr[63:MEM_AW+1], imem_inval, base};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      base            <= '0;
      fault_q         <= 1'b0;
      beat            <= '0;
      win_q           <= '0;
      mem_en          <= 1'b0;
      mem_addr        <= '0;
      imem_data       <= '0;
      imem_data_valid <= 1'b0;
      imem_fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_addr_valid) begin
            base    <= req_base;
            fault_q <= imem_addr[0];
`ifdef IMEM_LAST_HIT_EN
            if (hit) begin
              state           <= DONE;
              imem_data       <= hit_data;
              imem_data_valid <= 1'b1;
              imem_fault      <= imem_addr[0];
            end else begin
`else
            begin
`endif
              state    <= READ;
              mem_en   <= 1'b1;
              mem_addr <= req_base;
              beat     <= '0;
            end
          end
        end
        READ: begin
          // RAM returns data one cycle after issue, so each beat stores the previous one.
          if (beat != 2'd0) win_q <= put_hw(win_q, beat - 2'd1, mem_rdata);
          if (beat == 2'(IMEM_BEATS-1)) begin
            state  <= DRAIN;
            mem_en <= 1'b0;
          end else begin
            beat     <= beat + 2'd1;
            mem_addr <= mem_addr + MEM_AW'(1);
          end
        end
        DRAIN: begin
          imem_data       <= put_hw(win_q, 2'd3, mem_rdata);
          imem_data_valid <= 1'b1;
          imem_fault      <= fault_q;
          state           <= DONE;
        end
        DONE: begin
          imem_data_valid <= 1'b0;
          imem_fault      <= 1'b0;
          beat            <= '0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the target end of the imem bus driven by the fetch unit.
- Accepts a halfword-aligned byte address and reads four consecutive halfwords from a 16-bit synchronous instruction RAM.
- Assembles them into one 64-bit instruction window and returns it with a one-cycle data-valid pulse.
- Sits between fetch and the instruction RAM/ROM macro.

Parameters:
MEM_AW, 16, halfword-index address width of the backing RAM (capacity 2^MEM_AW halfwords)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  input  64  byte address of requested window
imem_addr_valid  input  1  request present; sampled only in IDLE
imem_inval  input  1  invalidate last-hit buffer (ignored without feature)
imem_data  output  64  assembled window; first halfword in [63:48], last in [15:0]
imem_data_valid  output  1  one-cycle pulse, imem_data/imem_fault valid
imem_fault  output  1  request had imem_addr[0]=1; valid with imem_data_valid
mem_addr  output  MEM_AW  halfword index to RAM
mem_en  output  1  RAM read enable
mem_rdata  input  16  RAM read data, valid one cycle after mem_en

Behaviour:
- Reset (async, rst=1): state IDLE; imem_data=0, imem_data_valid=0, imem_fault=0, mem_en=0, mem_addr=0, beat counter=0. Any in-flight transaction is abandoned; reads returning after reset release are discarded.
- States: IDLE, READ, DRAIN, DONE.
- IDLE, imem_addr_valid=1:
  - Latch base=imem_addr[MEM_AW:1] and fault=imem_addr[0].
  - Go to READ.
  - Address bits above MEM_AW are ignored.
- READ (4 cycles):
  - mem_en=1, mem_addr=base+beat, with beat running 0..3.
  - Addition is modulo 2^MEM_AW, so the window wraps at the top of RAM.
- Capture: mem_rdata for beat k is captured one cycle after issue into slot k: beat 0 -> [63:48], beat 1 -> [47:32], beat 2 -> [31:16], beat 3 -> [15:0].
- DRAIN (1 cycle): mem_en=0; beat 3 data captured.
- DONE (1 cycle): imem_data_valid=1, imem_fault=latched fault; then IDLE.
- imem_data holds its value until the next DONE; it is not cleared between transactions.
- Latency: capture edge at end of cycle 0; READ in cycles 1-4; DRAIN in cycle 5; imem_data_valid high in cycle 6.
- New request: the earliest new request is sampled in cycle 7, i.e. the first IDLE cycle. The fetch unit advances its PC on the DONE edge, so the new address is stable by then.
- imem_addr and imem_addr_valid changing after capture have no effect; the transaction always completes.
- Misaligned address: bit 0 is dropped, the aligned window is returned, and imem_fault=1 for that response.
- imem_addr_valid held permanently high gives back-to-back transactions, one every 7 cycles.

Optional Feature:
- Macro: IMEM_LAST_HIT_EN.
- With the macro:
  - One-entry buffer holds {valid, tag=base, data} of the last completed window.
  - IDLE with imem_addr_valid=1 and imem_addr[MEM_AW:1] equal to a valid tag goes directly to DONE: imem_data_valid in cycle 1, no mem_en issued, imem_fault taken from the current request.
  - A miss follows the normal path and refills the buffer at DONE.
  - imem_inval=1 clears valid on the next edge. Inval in the same cycle as a DONE refill wins, leaving valid=0.
  - Reset clears valid.
- Without the macro: no buffer, imem_inval unused, every request takes 6 cycles to response.

Decomposition:
- Shared package raisin64_imem_pkg holds:
  - state enum {IDLE, READ, DRAIN, DONE}
  - IMEM_BEATS=4
  - IMEM_HW_W=16
  - IMEM_WIN_W=64
- Optional sub-module imem_last_hit (tag/data/valid register plus compare), instantiated only under IMEM_LAST_HIT_EN.
- The core FSM stays in imem_responder.

Test Plan:
- RAM hw[i]=16'h1000+i, imem_addr=0x0 pulse -> mem_addr 0,1,2,3 in cycles 1-4; imem_data=0x1000_1001_1002_1003, imem_data_valid high only in cycle 6, imem_fault=0.
- imem_addr=0x6 -> imem_data=0x1003_1004_1005_1006. Then imem_addr_valid held high with address 0xE -> second response 7 cycles after the first, 0x1007_1008_1009_100A.
- imem_addr=0x5 -> same data as 0x4 (0x1002_1003_1004_1005), imem_fault=1 in the valid cycle only.
- MEM_AW=16, imem_addr=0x1_FFFC -> mem_addr 0xFFFE,0xFFFF,0x0000,0x0001; imem_data=0x0FFE_0FFF_1000_1001 (hw values truncated to 16 bits).
- rst asserted in cycle 3 of a transaction -> outputs 0 immediately, no imem_data_valid. After release, a request to 0x0 completes normally in 6 cycles.
- IMEM_LAST_HIT_EN: request 0x0 twice -> second response in cycle 1 with no mem_en. Assert imem_inval, request 0x0 again -> full 6-cycle path.
